// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned DIV_W_DEF       = 16;
  localparam int unsigned DEFAULT_DIV_DEF = 4;
  localparam int unsigned MIN_DIV         = 2;

  typedef logic [DIV_W_DEF-1:0] div_t;

endpackage : clkdiv_pkg

// File: rtl/clock_divider_prog_toggle_stage.sv
// Divide-by-two cascade stage: q flips on every step; rise flags a 0->1 flip.
module toggle_stage (
  input  logic clki,
  input  logic rsti_n,
  input  logic step,
  output logic q,
  output logic rise
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (step) q_d = ~q_q;
  end

  always_ff @(posedge clki) begin
    if (!rsti_n) q_q <= 1'b0;
    else         q_q <= q_d;
  end

  assign q    = q_q;
  assign rise = step & ~q_q;

endmodule : toggle_stage

// File: rtl/clock_divider_prog.sv
// Programmable divider: period-N square wave, 2N/4N cascade and period tick,
// with a divisor reload that only lands on a period boundary.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clki,
  input  logic             rsti_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_data,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic             tick,
  output logic [2:0]       clko
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_N = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_act_q, n_act_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] n_new;
  logic             pending_q, pending_d;
  logic             clk0_q, clk0_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             wrap;
  logic             accept;
  logic             data_ok;
  logic             step1;
  logic             rise1;
  logic             q1;
  logic             q2;
  logic             unused_rise2;

  // Next-state: counting, handshake, and where a pending divisor lands.
  always_comb begin
    accept    = div_valid & ~pending_q;
    data_ok   = (div_data >= MIN_N);
    wrap      = (cnt_q == (n_act_q - ONE));
    cnt_inc   = wrap ? '0 : (cnt_q + ONE);
    n_new     = (wrap && pending_q) ? shadow_q : n_act_q;

    cnt_d     = cnt_q;
    n_act_d   = n_act_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk0_d    = clk0_q;
    tick_d    = 1'b0;
    err_d     = accept & ~data_ok;
    step1     = 1'b0;

    if (en) begin
      cnt_d  = cnt_inc;
      // Duty compare uses the divisor that is active after this edge.
      clk0_d = (cnt_inc < (n_new >> 1));
      tick_d = wrap;
      step1  = wrap;
      if (wrap && pending_q) begin
        n_act_d   = shadow_q;
        pending_d = 1'b0;
      end
    end else if (pending_q) begin
      // Park the counter one short of wrap so re-enable starts a fresh period.
      n_act_d   = shadow_q;
      cnt_d     = shadow_q - ONE;
      clk0_d    = 1'b0;
      pending_d = 1'b0;
    end

    if (accept && data_ok) begin
      shadow_d  = div_data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clki) begin
    if (!rsti_n) begin
      cnt_q     <= DEF_N - ONE;
      n_act_q   <= DEF_N;
      shadow_q  <= DEF_N;
      pending_q <= 1'b0;
      clk0_q    <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      n_act_q   <= n_act_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk0_q    <= clk0_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  toggle_stage u_stage1 (
    .clki   (clki),
    .rsti_n (rsti_n),
    .step   (step1),
    .q      (q1),
    .rise   (rise1)
  );

  toggle_stage u_stage2 (
    .clki   (clki),
    .rsti_n (rsti_n),
    .step   (rise1),
    .q      (q2),
    .rise   (unused_rise2)
  );

  assign div_ready = ~pending_q;
  assign div_err   = err_q;
  assign tick      = tick_q;
  assign clko      = {q2, q1, clk0_q};

endmodule : clock_divider_prog

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: reference model feeds a scoreboard.
module tb_clock_divider_prog;
  import clkdiv_pkg::*;

  logic       clki = 1'b0;
  logic       rsti_n;
  logic       en;
  div_t       div_data;
  logic       div_valid;
  logic       div_ready;
  logic       div_err;
  logic       tick;
  logic [2:0] clko;

  int checks = 0;
  int errors = 0;

  logic [5:0] sb_q[$];

  div_t m_cnt, m_n, m_sh;
  logic m_pend, m_c0, m_c1, m_c2, m_tick, m_err;

  clock_divider_prog dut (
    .clki      (clki),
    .rsti_n    (rsti_n),
    .en        (en),
    .div_data  (div_data),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_err   (div_err),
    .tick      (tick),
    .clko      (clko)
  );

  always #5 clki = ~clki;

  // Behavioural reference for one clki edge.
  task automatic model_edge(input logic r, input logic e, input logic v, input div_t d);
    logic acc;
    logic wrap;
    div_t nxt;
    div_t nn;
    if (!r) begin
      m_cnt = div_t'(3); m_n = div_t'(4); m_pend = 1'b0;
      m_c0 = 1'b0; m_c1 = 1'b0; m_c2 = 1'b0; m_tick = 1'b0; m_err = 1'b0;
    end else begin
      acc   = v && !m_pend;
      m_err = acc && (d < div_t'(2));
      if (e) begin
        wrap   = (m_cnt == div_t'(m_n - div_t'(1)));
        nxt    = wrap ? div_t'(0) : div_t'(m_cnt + div_t'(1));
        nn     = (wrap && m_pend) ? m_sh : m_n;
        m_c0   = (nxt < div_t'(nn / div_t'(2)));
        m_tick = wrap;
        m_cnt  = nxt;
        if (wrap) begin
          if (!m_c1) m_c2 = !m_c2;
          m_c1 = !m_c1;
          if (m_pend) begin m_n = m_sh; m_pend = 1'b0; end
        end
      end else begin
        m_tick = 1'b0;
        if (m_pend) begin
          m_n = m_sh; m_cnt = div_t'(m_sh - div_t'(1)); m_c0 = 1'b0; m_pend = 1'b0;
        end
      end
      if (acc && d >= div_t'(2)) begin m_sh = d; m_pend = 1'b1; end
    end
  endtask

  // Apply inputs for one edge, push the model's prediction, step past the edge.
  task automatic drive(input logic r, input logic e, input logic v, input div_t d);
    rsti_n = r; en = e; div_valid = v; div_data = d;
    model_edge(r, e, v, d);
    sb_q.push_back({!m_pend, m_err, m_tick, m_c2, m_c1, m_c0});
    @(posedge clki);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    for (int c = 0; c < 3; c++) begin
      drive(c == 2, 1'b1, c == 1, div_t'(9));
      exp = sb_q.pop_front();
      checks++;
      if ({div_ready, div_err, tick, clko} !== exp) begin
        errors++;
        $display("FAIL reset_sb c=%0d got %b exp %b", c, {div_ready, div_err, tick, clko}, exp);
      end
      checks++;
      if (c < 2 && {div_ready, div_err, tick, clko} !== 6'b100000) begin
        errors++;
        $display("FAIL reset_val c=%0d got %b exp 100000", c, {div_ready, div_err, tick, clko});
      end else if (c == 2 && {div_ready, div_err, tick, clko} !== 6'b101111) begin
        errors++;
        $display("FAIL first_wrap got %b exp 101111", {div_ready, div_err, tick, clko});
      end
    end
  endtask

  task automatic test_default_period();
    logic [5:0] exp;
    int ticks = 0, c0_hi = 0, c1_hi = 0;
    for (int c = 0; c <= 16; c++) begin
      drive(c != 0, 1'b1, 1'b0, div_t'(0));
      exp = sb_q.pop_front();
      checks++;
      if ({div_ready, div_err, tick, clko} !== exp) begin
        errors++;
        $display("FAIL default_sb c=%0d got %b exp %b", c, {div_ready, div_err, tick, clko}, exp);
      end
      if (c != 0) begin ticks += int'(tick); c0_hi += int'(clko[0]); c1_hi += int'(clko[1]); end
    end
    checks++;
    if (ticks != 4 || c0_hi != 8 || c1_hi != 8) begin
      errors++;
      $display("FAIL default_counts got ticks=%0d c0=%0d c1=%0d exp 4/8/8", ticks, c0_hi, c1_hi);
    end
  endtask

  task automatic test_load();
    logic [5:0] exp;
    int tq[$];
    int exp_t[4] = '{1, 5, 10, 15};
    for (int c = 0; c <= 16; c++) begin
      drive(c != 0, 1'b1, c == 3, div_t'(5));
      exp = sb_q.pop_front();
      checks++;
      if ({div_ready, div_err, tick, clko} !== exp) begin
        errors++;
        $display("FAIL load_sb c=%0d got %b exp %b", c, {div_ready, div_err, tick, clko}, exp);
      end
      if (c != 0 && tick) tq.push_back(c);
      if (c == 4 || c == 5) begin
        checks++;
        if (div_ready !== (c == 5)) begin
          errors++;
          $display("FAIL load_ready c=%0d got %b exp %b", c, div_ready, c == 5);
        end
      end
    end
    checks++;
    if (tq.size() != 4) begin errors++; $display("FAIL load_ticks got %0d exp 4", tq.size()); end
    for (int i = 0; i < 4 && i < tq.size(); i++) begin
      checks++;
      if (tq[i] != exp_t[i]) begin
        errors++; $display("FAIL load_tick_at i=%0d got %0d exp %0d", i, tq[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_bad_div();
    logic [5:0] exp;
    int errs = 0, not_ready = 0, ticks = 0;
    for (int c = 0; c <= 12; c++) begin
      drive(c != 0, 1'b1, c == 2 || c == 4, (c == 2) ? div_t'(1) : div_t'(0));
      exp = sb_q.pop_front();
      checks++;
      if ({div_ready, div_err, tick, clko} !== exp) begin
        errors++;
        $display("FAIL baddiv_sb c=%0d got %b exp %b", c, {div_ready, div_err, tick, clko}, exp);
      end
      errs += int'(div_err); not_ready += int'(!div_ready); ticks += int'(tick);
    end
    checks++;
    if (errs != 2 || not_ready != 0 || ticks != 3) begin
      errors++;
      $display("FAIL baddiv_counts got err=%0d notready=%0d ticks=%0d exp 2/0/3", errs, not_ready, ticks);
    end
  endtask

  task automatic test_disable();
    logic [5:0] exp;
    int tq[$];
    int exp_t[3] = '{1, 14, 20};
    int c0_hi = 0;
    for (int c = 0; c <= 20; c++) begin
      drive(c != 0, !(c >= 4 && c <= 13), c == 6, div_t'(6));
      exp = sb_q.pop_front();
      checks++;
      if ({div_ready, div_err, tick, clko} !== exp) begin
        errors++;
        $display("FAIL disable_sb c=%0d got %b exp %b", c, {div_ready, div_err, tick, clko}, exp);
      end
      if (c != 0 && tick) tq.push_back(c);
      if (c >= 14 && c <= 19) c0_hi += int'(clko[0]);
    end
    checks++;
    if (tq.size() != 3 || c0_hi != 3) begin
      errors++; $display("FAIL disable_counts got ticks=%0d c0=%0d exp 3/3", tq.size(), c0_hi);
    end
    for (int i = 0; i < 3 && i < tq.size(); i++) begin
      checks++;
      if (tq[i] != exp_t[i]) begin
        errors++; $display("FAIL disable_tick_at i=%0d got %0d exp %0d", i, tq[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [5:0] exp;
    int tq[$];
    int exp_t[4] = '{1, 4, 8, 12};
    for (int c = 0; c <= 13; c++) begin
      drive(c != 0 && c != 3, 1'b1, c == 2, div_t'(7));
      exp = sb_q.pop_front();
      checks++;
      if ({div_ready, div_err, tick, clko} !== exp) begin
        errors++;
        $display("FAIL rstpend_sb c=%0d got %b exp %b", c, {div_ready, div_err, tick, clko}, exp);
      end
      if (c == 3) begin
        checks++;
        if ({div_ready, div_err, tick, clko} !== 6'b100000) begin
          errors++; $display("FAIL rstpend_val got %b exp 100000", {div_ready, div_err, tick, clko});
        end
      end
      if (c != 0 && tick) tq.push_back(c);
    end
    checks++;
    if (tq.size() != 4) begin errors++; $display("FAIL rstpend_ticks got %0d exp 4", tq.size()); end
    for (int i = 0; i < 4 && i < tq.size(); i++) begin
      checks++;
      if (tq[i] != exp_t[i]) begin
        errors++; $display("FAIL rstpend_tick_at i=%0d got %0d exp %0d", i, tq[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    int tq[$];
    int exp_t[5] = '{1, 5, 11, 19, 27};
    int phase = 0, acc2_at = -1;
    logic v, pend_before;
    for (int c = 0; c <= 28; c++) begin
      v = (c != 0) && (phase < 2);
      pend_before = m_pend;
      drive(c != 0, 1'b1, v, (phase == 0) ? div_t'(6) : div_t'(8));
      if (c != 0 && v && !pend_before) begin
        if (phase == 1) acc2_at = c;
        phase++;
      end
      exp = sb_q.pop_front();
      checks++;
      if ({div_ready, div_err, tick, clko} !== exp) begin
        errors++;
        $display("FAIL b2b_sb c=%0d got %b exp %b", c, {div_ready, div_err, tick, clko}, exp);
      end
      if (c != 0 && tick) tq.push_back(c);
    end
    checks++;
    if (acc2_at != 6 || tq.size() != 5) begin
      errors++; $display("FAIL b2b_accept got acc2=%0d ticks=%0d exp 6/5", acc2_at, tq.size());
    end
    for (int i = 0; i < 5 && i < tq.size(); i++) begin
      checks++;
      if (tq[i] != exp_t[i]) begin
        errors++; $display("FAIL b2b_tick_at i=%0d got %0d exp %0d", i, tq[i], exp_t[i]);
      end
    end
  endtask

  initial begin
    rsti_n = 1'b0; en = 1'b0; div_valid = 1'b0; div_data = '0;
    m_sh = div_t'(4);
    #1;
    test_reset();
    test_default_period();
    test_load();
    test_bad_div();
    test_disable();
    test_reset_pending();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule : tb_clock_divider_prog
